// File: rtl/mips_pkg.sv
// Shared constants and fetch-state encoding for the MIPS front end.
package mips_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_0000;

  localparam logic [1:0] FS_IDLE  = 2'd0;
  localparam logic [1:0] FS_REQ   = 2'd1;
  localparam logic [1:0] FS_HOLD  = 2'd2;
  localparam logic [1:0] FS_DRAIN = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = FS_IDLE,
    REQ   = FS_REQ,
    HOLD  = FS_HOLD,
    DRAIN = FS_DRAIN
  } fetch_state_t;

endpackage

// File: rtl/mips_if_stage_if_id_reg.sv
// IF/ID pipeline register: flush beats load, load beats stall-hold,
// and an unstalled register with no new load is considered consumed.
module if_id_reg
  import mips_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic              flush,
  input  logic              stall,
  input  logic [31:0]       load_instr,
  input  logic [ADDR_W-1:0] load_pc4,
  output logic              valid,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] pc4
);

  // Register update with flush > load > hold > consume priority.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      instr <= NOP_INSTR;
      pc4   <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= load_instr;
      pc4   <= load_pc4;
    end else if (!stall) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/mips_if_stage.sv
// Instruction fetch stage: owns the PC, issues one outstanding imem request,
// fills the IF/ID register, absorbs stalls with a one-entry skid buffer and
// squashes wrong-path fetches on redirect.
//
// state | meaning
// IDLE  | just out of reset, first request next cycle
// REQ   | request to pc outstanding
// HOLD  | fetched word parked in skid, waiting for decode
// DRAIN | redirect seen mid-request, discarding the old response
module mips_if_stage
  import mips_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] PC_RESET = ADDR_W'(PC_RESET_DEFAULT)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [31:0]       imem_rdata,
  output logic              ifid_valid,
  output logic [31:0]       ifid_instr,
  output logic [ADDR_W-1:0] ifid_pc4,
  output logic [ADDR_W-1:0] fetch_pc
);

  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);
  localparam logic [ADDR_W-1:0] FOUR      = ADDR_W'(4);

  fetch_state_t      state, state_next;
  logic [ADDR_W-1:0] pc, pc_next, pc_plus4, target;
  logic [ADDR_W-1:0] redir_reg, redir_next;
  logic [31:0]       skid_instr;
  logic [ADDR_W-1:0] skid_pc4;
  logic              skid_we;
  logic              can_accept;
  logic              ifid_load;
  logic [31:0]       ifid_load_instr;
  logic [ADDR_W-1:0] ifid_load_pc4;

  assign pc_plus4   = pc + FOUR;
  assign target     = redirect_pc & WORD_MASK;
  assign can_accept = !ifid_valid || !stall;

  // The PC only moves between requests, so it doubles as the request address.
  assign imem_req  = (state == REQ) || (state == DRAIN);
  assign imem_addr = pc;
  assign fetch_pc  = pc;

  // State, PC, skid and pending-redirect registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      pc         <= PC_RESET;
      redir_reg  <= '0;
      skid_instr <= NOP_INSTR;
      skid_pc4   <= '0;
    end else begin
      state     <= state_next;
      pc        <= pc_next;
      redir_reg <= redir_next;
      if (skid_we) begin
        skid_instr <= imem_rdata;
        skid_pc4   <= pc_plus4;
      end
    end
  end

  // Next-state, next-PC and IF/ID load decisions.
  always_comb begin
    state_next      = state;
    pc_next         = pc;
    redir_next      = redir_reg;
    skid_we         = 1'b0;
    ifid_load       = 1'b0;
    ifid_load_instr = imem_rdata;
    ifid_load_pc4   = pc_plus4;
    case (state)
      IDLE: state_next = REQ;
      REQ: begin
        if (imem_ready) begin
          if (redirect_valid) begin
            pc_next = target;
          end else if (can_accept) begin
            ifid_load = 1'b1;
            pc_next   = pc_plus4;
          end else begin
            skid_we    = 1'b1;
            pc_next    = pc_plus4;
            state_next = HOLD;
          end
        end else if (redirect_valid) begin
          redir_next = target;
          state_next = DRAIN;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_next    = target;
          state_next = REQ;
        end else if (!stall) begin
          ifid_load       = 1'b1;
          ifid_load_instr = skid_instr;
          ifid_load_pc4   = skid_pc4;
          state_next      = REQ;
        end
      end
      DRAIN: begin
        if (redirect_valid) redir_next = target;
        if (imem_ready) begin
          pc_next    = redirect_valid ? target : redir_reg;
          state_next = REQ;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  if_id_reg #(.ADDR_W(ADDR_W)) u_if_id_reg (
    .clock      (clock),
    .reset      (reset),
    .load       (ifid_load),
    .flush      (redirect_valid),
    .stall      (stall),
    .load_instr (ifid_load_instr),
    .load_pc4   (ifid_load_pc4),
    .valid      (ifid_valid),
    .instr      (ifid_instr),
    .pc4        (ifid_pc4)
  );

endmodule

// File: tb/tb_mips_if_stage.sv
// Bench for mips_if_stage: directed scenarios plus a randomized stream
// checked against an in-order instruction-address model.
module tb_mips_if_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        ready_en = 1'b1;
  logic        imem_req, imem_ready;
  logic [31:0] imem_addr, imem_rdata;
  logic        ifid_valid;
  logic [31:0] ifid_instr, ifid_pc4, fetch_pc;

  logic        stall2 = 1'b0;
  logic        redirect_valid2 = 1'b0;
  logic [31:0] redirect_pc2 = 32'h0;
  logic        imem_req2, imem_ready2;
  logic [31:0] imem_addr2, imem_rdata2;
  logic        ifid_valid2;
  logic [31:0] ifid_instr2, ifid_pc42, fetch_pc2;

  int n_pass = 0;
  int n_total = 0;

  always #5 clock = ~clock;

  // Memory model: word at address A is A | 0xA000_0000.
  assign imem_ready  = imem_req & ready_en;
  assign imem_rdata  = imem_addr | 32'hA000_0000;
  assign imem_ready2 = imem_req2;
  assign imem_rdata2 = imem_addr2 | 32'hA000_0000;

  mips_if_stage dut (
    .clock(clock), .reset(reset), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .ifid_valid(ifid_valid), .ifid_instr(ifid_instr),
    .ifid_pc4(ifid_pc4), .fetch_pc(fetch_pc)
  );

  mips_if_stage #(.ADDR_W(32), .PC_RESET(32'hFFFF_FFFC)) dut_wrap (
    .clock(clock), .reset(reset), .stall(stall2),
    .redirect_valid(redirect_valid2), .redirect_pc(redirect_pc2),
    .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_ready(imem_ready2), .imem_rdata(imem_rdata2),
    .ifid_valid(ifid_valid2), .ifid_instr(ifid_instr2),
    .ifid_pc4(ifid_pc42), .fetch_pc(fetch_pc2)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; ready_en = 1'b1; stall = 1'b0; redirect_valid = 1'b0;
    step(); step();
    n_total++;
    if (ifid_valid !== 1'b0 || imem_req !== 1'b0)
      $display("FAIL reset_outputs: valid=%b req=%b, want 0 0", ifid_valid, imem_req);
    else n_pass++;
    n_total++;
    if (fetch_pc !== 32'h0 || ifid_instr !== 32'h0 || ifid_pc4 !== 32'h0)
      $display("FAIL reset_regs: pc=%h instr=%h pc4=%h, want 0 0 0", fetch_pc, ifid_instr, ifid_pc4);
    else n_pass++;
    reset = 1'b1;
  endtask

  task automatic test_stream();
    step();
    n_total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0)
      $display("FAIL stream_addr0: req=%b addr=%h, want 1 00000000", imem_req, imem_addr);
    else n_pass++;
    step();
    n_total++;
    if (imem_addr !== 32'h4 || ifid_valid !== 1'b1 || ifid_instr !== 32'hA000_0000 || ifid_pc4 !== 32'h4)
      $display("FAIL stream_w0: addr=%h v=%b instr=%h pc4=%h, want 4 1 a0000000 4",
               imem_addr, ifid_valid, ifid_instr, ifid_pc4);
    else n_pass++;
    step();
    n_total++;
    if (imem_addr !== 32'h8 || ifid_instr !== 32'hA000_0004 || ifid_pc4 !== 32'h8)
      $display("FAIL stream_w1: addr=%h instr=%h pc4=%h, want 8 a0000004 8", imem_addr, ifid_instr, ifid_pc4);
    else n_pass++;
    step();
    n_total++;
    if (imem_addr !== 32'hC || ifid_instr !== 32'hA000_0008)
      $display("FAIL stream_w2: addr=%h instr=%h, want c a0000008", imem_addr, ifid_instr);
    else n_pass++;
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_total++;
      if (imem_req !== 1'b0 || ifid_valid !== 1'b1 || ifid_instr !== 32'hA000_0008 || ifid_pc4 !== 32'hC)
        $display("FAIL stall_hold%0d: req=%b v=%b instr=%h pc4=%h, want 0 1 a0000008 c",
                 i, imem_req, ifid_valid, ifid_instr, ifid_pc4);
      else n_pass++;
    end
    stall = 1'b0;
    step();
    n_total++;
    if (ifid_valid !== 1'b1 || ifid_instr !== 32'hA000_000C || ifid_pc4 !== 32'h10 || imem_addr !== 32'h10)
      $display("FAIL stall_release: v=%b instr=%h pc4=%h addr=%h, want 1 a000000c 10 10",
               ifid_valid, ifid_instr, ifid_pc4, imem_addr);
    else n_pass++;
  endtask

  task automatic test_redirect_zero_wait();
    redirect_valid = 1'b1; redirect_pc = 32'h103;
    step();
    redirect_valid = 1'b0;
    n_total++;
    if (ifid_valid !== 1'b0 || imem_addr !== 32'h100)
      $display("FAIL redir0_flush: v=%b addr=%h, want 0 100", ifid_valid, imem_addr);
    else n_pass++;
    step();
    n_total++;
    if (ifid_valid !== 1'b1 || ifid_instr !== 32'hA000_0100 || ifid_pc4 !== 32'h104)
      $display("FAIL redir0_target: v=%b instr=%h pc4=%h, want 1 a0000100 104", ifid_valid, ifid_instr, ifid_pc4);
    else n_pass++;
  endtask

  task automatic test_redirect_wait();
    redirect_valid = 1'b1; redirect_pc = 32'h20;
    step();
    redirect_valid = 1'b0;
    n_total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h20)
      $display("FAIL redirw_req: req=%b addr=%h, want 1 20", imem_req, imem_addr);
    else n_pass++;
    ready_en = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h200;
    step();
    redirect_valid = 1'b0;
    n_total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h20 || ifid_valid !== 1'b0)
      $display("FAIL redirw_wait1: req=%b addr=%h v=%b, want 1 20 0", imem_req, imem_addr, ifid_valid);
    else n_pass++;
    step();
    n_total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h20)
      $display("FAIL redirw_wait2: req=%b addr=%h, want 1 20", imem_req, imem_addr);
    else n_pass++;
    ready_en = 1'b1;
    step();
    n_total++;
    if (imem_addr !== 32'h200 || ifid_valid !== 1'b0)
      $display("FAIL redirw_drop: addr=%h v=%b, want 200 0", imem_addr, ifid_valid);
    else n_pass++;
    step();
    n_total++;
    if (ifid_valid !== 1'b1 || ifid_instr !== 32'hA000_0200)
      $display("FAIL redirw_target: v=%b instr=%h, want 1 a0000200", ifid_valid, ifid_instr);
    else n_pass++;
  endtask

  task automatic test_stall_redirect();
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h300;
    step();
    stall = 1'b0; redirect_valid = 1'b0;
    n_total++;
    if (ifid_valid !== 1'b0 || imem_addr !== 32'h300)
      $display("FAIL stallredir_flush: v=%b addr=%h, want 0 300", ifid_valid, imem_addr);
    else n_pass++;
    step();
    n_total++;
    if (ifid_valid !== 1'b1 || ifid_instr !== 32'hA000_0300)
      $display("FAIL stallredir_target: v=%b instr=%h, want 1 a0000300", ifid_valid, ifid_instr);
    else n_pass++;
  endtask

  task automatic test_wrap_and_async_reset();
    ready_en = 1'b0;
    step();
    n_total++;
    if (imem_req !== 1'b1)
      $display("FAIL areset_pre: req=%b, want 1", imem_req);
    else n_pass++;
    #2 reset = 1'b0;
    #1;
    n_total++;
    if (imem_req !== 1'b0 || fetch_pc !== 32'h0 || imem_req2 !== 1'b0)
      $display("FAIL areset_drop: req=%b pc=%h req2=%b, want 0 0 0", imem_req, fetch_pc, imem_req2);
    else n_pass++;
    ready_en = 1'b1;
    @(posedge clock); #1 reset = 1'b1;
    step();
    n_total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || imem_req2 !== 1'b1 || imem_addr2 !== 32'hFFFF_FFFC)
      $display("FAIL wrap_first: req=%b addr=%h req2=%b addr2=%h, want 1 0 1 fffffffc",
               imem_req, imem_addr, imem_req2, imem_addr2);
    else n_pass++;
    step();
    n_total++;
    if (ifid_valid2 !== 1'b1 || ifid_instr2 !== 32'hFFFF_FFFC || ifid_pc42 !== 32'h0 || imem_addr2 !== 32'h0)
      $display("FAIL wrap_pc4: v=%b instr=%h pc4=%h addr=%h, want 1 fffffffc 0 0",
               ifid_valid2, ifid_instr2, ifid_pc42, imem_addr2);
    else n_pass++;
    n_total++;
    if (ifid_instr !== 32'hA000_0000 || ifid_pc4 !== 32'h4)
      $display("FAIL areset_restart: instr=%h pc4=%h, want a0000000 4", ifid_instr, ifid_pc4);
    else n_pass++;
  endtask

  // Model: decode must see instructions in program order, one per address,
  // restarting at the word-aligned target after every redirect.
  task automatic test_random_stream();
    logic [31:0] exp_addr;
    logic        pend, held;
    logic [31:0] pend_addr, held_instr, held_pc4;
    int          idle;
    reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0; ready_en = 1'b1;
    step();
    reset = 1'b1;
    exp_addr = 32'h0; pend = 1'b0; held = 1'b0; idle = 0;
    pend_addr = 32'h0; held_instr = 32'h0; held_pc4 = 32'h0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      stall          = ($urandom_range(0, 2) == 0);
      ready_en       = ($urandom_range(0, 2) != 0);
      redirect_valid = ($urandom_range(0, 11) == 0);
      redirect_pc    = $urandom_range(0, 32'h0FFF_FFFF);
      #1;
      if (imem_req) begin
        n_total++;
        if (imem_addr[1:0] !== 2'b00)
          $display("FAIL rnd_align c%0d: addr=%h, want low bits 00", cyc, imem_addr);
        else n_pass++;
      end
      if (pend) begin
        n_total++;
        if (imem_req !== 1'b1 || imem_addr !== pend_addr)
          $display("FAIL rnd_addr_stable c%0d: req=%b addr=%h, want 1 %h", cyc, imem_req, imem_addr, pend_addr);
        else n_pass++;
      end
      if (held) begin
        n_total++;
        if (ifid_valid !== 1'b1 || ifid_instr !== held_instr || ifid_pc4 !== held_pc4)
          $display("FAIL rnd_hold c%0d: v=%b instr=%h pc4=%h, want 1 %h %h",
                   cyc, ifid_valid, ifid_instr, ifid_pc4, held_instr, held_pc4);
        else n_pass++;
      end
      if (ifid_valid && !redirect_valid) begin
        n_total++;
        if (ifid_instr !== (exp_addr | 32'hA000_0000) || ifid_pc4 !== exp_addr + 32'd4)
          $display("FAIL rnd_order c%0d: instr=%h pc4=%h, want %h %h",
                   cyc, ifid_instr, ifid_pc4, exp_addr | 32'hA000_0000, exp_addr + 32'd4);
        else n_pass++;
      end
      pend       = imem_req && !imem_ready && !redirect_valid;
      pend_addr  = imem_addr;
      held       = ifid_valid && stall && !redirect_valid;
      held_instr = ifid_instr;
      held_pc4   = ifid_pc4;
      if (imem_req && !imem_ready && redirect_valid) pend = 1'b1;
      if (redirect_valid) begin
        exp_addr = redirect_pc & 32'hFFFF_FFFC;
        idle = 0;
      end else if (ifid_valid && !stall) begin
        exp_addr = exp_addr + 32'd4;
        idle = 0;
      end else begin
        idle++;
      end
      if (idle > 64) begin
        n_total++;
        $display("FAIL rnd_progress c%0d: %0d cycles without delivery, want <= 64", cyc, idle);
        break;
      end
      @(posedge clock);
      #1;
    end
    stall = 1'b0; redirect_valid = 1'b0; ready_en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_zero_wait();
    test_redirect_wait();
    test_stall_redirect();
    test_wrap_and_async_reset();
    test_random_stream();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
